i2s_codec_master: RTL
=====================

# i2s_codec_master

Clock master for the serial audio port: generates BCLK and a shared ADCLRCK/DACLRCK in I2S format, serialises parallel ADC samples onto ADCDAT, and deserialises DACDAT into parallel DAC samples. It is the codec-side counterpart of the audio core's external interface (ADCDAT, ADCLRCK, BCLK, DACDAT, DACLRCK). We use it as a WM8731 stand-in for loopback simulation and for driving the audio core from on-chip sources.

## Interface
- DATA_W, 24: sample width per channel. Legal range 1..31.
- BCLK_HALF, 8: BCLK half-period in clk_clk cycles. Must be ≥2. With the default, a 50 MHz clock gives a 3.125 MHz BCLK and 48.828 kHz Fs.

Ports:
- clk_clk  in  1  system clock, rising edge
- reset_reset  in  1  asynchronous, active-high reset
- bclk  out  1  bit clock
- adclrck  out  1  ADC word clock: 0 = left, 1 = right
- daclrck  out  1  DAC word clock, identical to adclrck
- adcdat  out  1  serial ADC data toward the audio core
- dacdat  in  1  serial DAC data from the audio core
- adc_left  in  DATA_W  left sample to transmit
- adc_right  in  DATA_W  right sample to transmit
- adc_valid  in  1  sample pair offered
- adc_ready  out  1  holding register empty
- dac_left  out  DATA_W  last received left sample
- dac_right  out  DATA_W  last received right sample
- dac_valid  out  1  one-cycle pulse: new dac_left/dac_right pair
- underrun  out  1  one-cycle pulse: frame started with no sample held

## Operation
- **Divider.** Counter runs 0..BCLK_HALF-1. At terminal count it wraps and toggles bclk. "Rise" and "fall" below mean the clk_clk cycle in which bclk goes 0→1 or 1→0.
- **Frame counter.** bit_idx runs 0..63 and advances on each fall.
  - Slot 0 (left) is bit_idx 0..31; slot 1 (right) is bit_idx 32..63.
  - lrck = bit_idx[5], registered, so it changes on a fall.
- **Slot layout (I2S, 32-bit slots).** Slot bit 0 carries 0. Slot bits 1..DATA_W carry the sample MSB-first. The remaining slot bits carry 0.
- **ADC path.**
  - One-entry holding register; adc_ready = !full.
  - A transfer occurs when adc_valid && adc_ready; it sets full.
  - Frame start is the fall on which bit_idx wraps 63→0.
    - If full: copy the held pair into the 64-bit shift register and clear full.
    - If not full: load zeros and pulse underrun.
  - If a transfer and a frame start coincide, the frame loads zeros, underrun pulses, and the new pair is held for the next frame.
  - adcdat is the shift register MSB and updates on every fall.
- **DAC path.**
  - dacdat is sampled on every rise into a 64-bit shift register.
  - At frame start, slot bits 1..DATA_W of each slot are copied to dac_left/dac_right, and dac_valid pulses for one cycle.
- **Reset (asynchronous).**
  - Counters 0, full 0, shift registers 0.
  - bclk=0, adclrck=daclrck=0, adcdat=0, adc_ready=1, dac_left=dac_right=0, dac_valid=0, underrun=0.
  - Reset mid-frame discards the partial frame. No dac_valid or underrun pulse is produced for it.
- The first frame after reset transmits zeros. Its start is the reset state itself, so no underrun pulse is generated for it.

## Timing
- BCLK period is 2·BCLK_HALF clk cycles. One frame is 128·BCLK_HALF clk cycles (1024 at default).
- The first rise occurs BCLK_HALF cycles after reset release. The first fall occurs 2·BCLK_HALF cycles after reset release.
- adcdat, adclrck and daclrck change only in the fall cycle. Data is stable for a full BCLK period around each rise.
- dacdat is sampled in the rise cycle.
- dac_valid and underrun are asserted in the cycle after the frame-start fall.
- ADC latency: a pair accepted before frame start N has its left MSB on adcdat at the second fall of frame N (slot bit 1).
- adc_ready deasserts in the cycle after a transfer. It reasserts in the cycle after the frame-start fall.

## Structure
- Package i2s_codec_pkg holds:
  - SLOT_BITS=32, FRAME_BITS=64, slot-bit-0 offset constant;
  - the frame_t struct (left, right).
- Sub-module i2s_bclk_gen contains the divider and bclk register. It outputs one-cycle rise_stb and fall_stb strobes.
- The top level holds bit_idx, the holding register, and both shift registers.

## Test plan
- **Reset.** Reset released → all outputs at their reset values. First bclk rise at cycle 8, first fall at cycle 16, adc_ready=1.
- **Loopback.** Tie adcdat→dacdat. Offer left 0xABCDEF, right 0x123456 before frame 1 → dac_valid at the end of frame 2 with dac_left=0xABCDEF, dac_right=0x123456.
- **Bit-level check.** Send left 0x800001 → adcdat=0 at slot bit 0, 1 at slot bit 1, 1 at slot bit 24, 0 at slot bits 25..31. lrck=0 throughout slot 0.
- **Underrun.** No adc_valid for two frames → two underrun pulses 1024 cycles apart, and adcdat held at 0.
- **Coincident transfer.** Assert adc_valid in the same cycle as the frame-start fall → underrun pulses, the pair is transmitted in the following frame, and adc_ready=0 until that frame's start.
- **Mid-frame reset.** Assert reset at bit_idx=40 → outputs return to reset values immediately. After release, the next dac_valid comes only after a full 1024-cycle frame.

Source files
------------

// File: rtl/i2s_codec_pkg.sv
// -----------------------------------------------------------------------------
// i2s_codec_pkg
// Shared constants, types and slot packing helpers for the I2S codec master.
//   SLOT_BITS / FRAME_BITS : 32-bit slots, two slots per frame
//   SLOT_DATA_OFS          : I2S one-bit delay; sample MSB sits in slot bit 1
//   frame_t                : left/right sample pair, held at maximum width
// -----------------------------------------------------------------------------
package i2s_codec_pkg;

  localparam int SLOT_BITS     = 32;
  localparam int FRAME_BITS    = 2 * SLOT_BITS;
  localparam int SLOT_DATA_OFS = 1;
  localparam int MAX_DATA_W    = SLOT_BITS - SLOT_DATA_OFS;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] left;
    logic [MAX_DATA_W-1:0] right;
  } frame_t;

  // Place a w-bit sample MSB-first into slot bits 1..w. The shift register
  // sends bit 31 first, so slot bit k lives at vector bit 31-k.
  function automatic logic [SLOT_BITS-1:0] pack_slot(input logic [MAX_DATA_W-1:0] s,
                                                     input int w);
    return {1'b0, s} << (SLOT_BITS - SLOT_DATA_OFS - w);
  endfunction

  // Inverse of pack_slot: recover slot bits 1..w as a right-aligned sample.
  function automatic logic [MAX_DATA_W-1:0] unpack_slot(input logic [SLOT_BITS-1:0] slot,
                                                        input int w);
    logic [SLOT_BITS-1:0] mask;
    mask = (SLOT_BITS'(1) << w) - SLOT_BITS'(1);
    return MAX_DATA_W'((slot >> (SLOT_BITS - SLOT_DATA_OFS - w)) & mask);
  endfunction

endpackage

// File: rtl/i2s_codec_bclk_gen.sv
// -----------------------------------------------------------------------------
// i2s_bclk_gen
// Bit-clock divider. A counter runs 0..BCLK_HALF-1; at terminal count it wraps
// and bclk toggles. The strobes are high in the clk cycle whose closing edge
// changes bclk, so logic qualified by them updates together with bclk.
//   clk_clk     : system clock
//   reset_reset : asynchronous active-high reset
//   bclk_o      : bit clock (registered)
//   rise_stb_o  : bclk goes 0->1 at the end of this cycle
//   fall_stb_o  : bclk goes 1->0 at the end of this cycle
// -----------------------------------------------------------------------------
module i2s_bclk_gen #(
  parameter int BCLK_HALF = 8
) (
  input  logic clk_clk,
  input  logic reset_reset,
  output logic bclk_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam int CNT_W = $clog2(BCLK_HALF);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bclk_q, bclk_d;
  logic             tc;

  assign tc = (cnt_q == CNT_W'(BCLK_HALF - 1));

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    cnt_d  = tc ? '0 : cnt_q + CNT_W'(1);
    bclk_d = bclk_q ^ tc;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample their inputs from the same edge regardless of statement order.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk_o     = bclk_q;
  assign rise_stb_o = tc & ~bclk_q;
  assign fall_stb_o = tc &  bclk_q;

endmodule

// File: rtl/i2s_codec_master.sv
// -----------------------------------------------------------------------------
// i2s_codec_master
// I2S clock master / codec stand-in. Generates bclk and a shared word clock,
// serialises ADC sample pairs onto adcdat and deserialises dacdat into DAC
// sample pairs. Frames are 64 bclk periods: left slot, then right slot.
//   clk_clk, reset_reset     : system clock, async active-high reset
//   bclk, adclrck, daclrck   : bit clock and word clock (0 = left)
//   adcdat / dacdat          : serial data out / in
//   adc_left/right/valid     : sample pair offered; adc_ready = holding reg empty
//   dac_left/right/valid     : last received pair, valid pulses once per frame
//   underrun                 : pulse when a frame starts with nothing held
// -----------------------------------------------------------------------------
module i2s_codec_master
  import i2s_codec_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int BCLK_HALF = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  output logic              bclk,
  output logic              adclrck,
  output logic              daclrck,
  output logic              adcdat,
  input  logic              dacdat,
  input  logic [DATA_W-1:0] adc_left,
  input  logic [DATA_W-1:0] adc_right,
  input  logic              adc_valid,
  output logic              adc_ready,
  output logic [DATA_W-1:0] dac_left,
  output logic [DATA_W-1:0] dac_right,
  output logic              dac_valid,
  output logic              underrun
);

  logic rise_stb, fall_stb;

  i2s_bclk_gen #(.BCLK_HALF(BCLK_HALF)) u_bclk_gen (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .bclk_o     (bclk),
    .rise_stb_o (rise_stb),
    .fall_stb_o (fall_stb)
  );

  logic [5:0]            bit_idx_q, bit_idx_d;
  logic                  full_q, full_d;
  frame_t                hold_q, hold_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d;
  logic [DATA_W-1:0]     dac_left_q, dac_left_d;
  logic [DATA_W-1:0]     dac_right_q, dac_right_d;
  logic                  dac_valid_q, dac_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  frame_start, xfer;

  assign frame_start = fall_stb && (bit_idx_q == 6'd63);
  assign xfer        = adc_valid && !full_q;

  always_comb begin
    bit_idx_d   = bit_idx_q;
    full_d      = full_q;
    hold_d      = hold_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    dac_left_d  = dac_left_q;
    dac_right_d = dac_right_q;
    dac_valid_d = 1'b0;
    underrun_d  = 1'b0;

    if (rise_stb) rx_d = {rx_q[FRAME_BITS-2:0], dacdat};

    if (fall_stb) begin
      bit_idx_d = bit_idx_q + 6'd1;
      tx_d      = {tx_q[FRAME_BITS-2:0], 1'b0};
    end

    // The last rise of the frame has already been shifted in, so rx_q holds
    // the whole frame in the same layout the transmitter uses.
    if (frame_start) begin
      dac_left_d  = DATA_W'(unpack_slot(rx_q[FRAME_BITS-1:SLOT_BITS], DATA_W));
      dac_right_d = DATA_W'(unpack_slot(rx_q[SLOT_BITS-1:0], DATA_W));
      dac_valid_d = 1'b1;
      if (full_q) begin
        tx_d   = {pack_slot(hold_q.left, DATA_W), pack_slot(hold_q.right, DATA_W)};
        full_d = 1'b0;
      end else begin
        tx_d       = '0;
        underrun_d = 1'b1;
      end
    end

    // A transfer needs !full_q, so it never conflicts with the clear above;
    // one landing on the frame-start cycle is simply held for the next frame.
    if (xfer) begin
      hold_d.left  = MAX_DATA_W'(adc_left);
      hold_d.right = MAX_DATA_W'(adc_right);
      full_d       = 1'b1;
    end
  end

  // NOTE: the shift and holding registers are reset too, so a mid-frame reset
  // discards the partial frame and the first frame after reset sends zeros.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      bit_idx_q   <= '0;
      full_q      <= 1'b0;
      hold_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      dac_left_q  <= '0;
      dac_right_q <= '0;
      dac_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      bit_idx_q   <= bit_idx_d;
      full_q      <= full_d;
      hold_q      <= hold_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      dac_left_q  <= dac_left_d;
      dac_right_q <= dac_right_d;
      dac_valid_q <= dac_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign adclrck   = bit_idx_q[5];
  assign daclrck   = bit_idx_q[5];
  assign adcdat    = tx_q[FRAME_BITS-1];
  assign adc_ready = !full_q;
  assign dac_left  = dac_left_q;
  assign dac_right = dac_right_q;
  assign dac_valid = dac_valid_q;
  assign underrun  = underrun_q;

endmodule
